// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Purpose  : Iterative radix-2 restoring divider (DIV/DIVU) for the E stage.
//            Optional macro DIV_EARLY_ZERO_EN: divide-by-zero skips iterations.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic             annul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall_div,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_divisor;
    logic                 r_negQuo;
    logic                 r_negRem;
    logic                 r_divZero;
    logic [WIDTH-1:0]     r_prevQuo;
    logic [WIDTH-1:0]     r_prevRem;

    logic                 w_accept;
    logic                 w_aNeg;
    logic                 w_bNeg;
    logic [WIDTH-1:0]     w_aMag;
    logic [WIDTH-1:0]     w_bMag;
    logic                 w_bZero;
    logic                 w_lastIter;
    logic [WIDTH:0]       w_shiftRem;
    logic [WIDTH:0]       w_diff;
    logic                 w_qBit;
    logic [WIDTH-1:0]     w_remNext;
    logic [WIDTH-1:0]     w_quoNext;
    logic [WIDTH-1:0]     w_quoFix;
    logic [WIDTH-1:0]     w_remFix;

    assign w_accept   = start & ~annul;
    assign w_aNeg     = signed_div & a[WIDTH-1];
    assign w_bNeg     = signed_div & b[WIDTH-1];
    assign w_aMag     = w_aNeg ? (~a + 1'b1) : a;
    assign w_bMag     = w_bNeg ? (~b + 1'b1) : b;
    assign w_bZero    = (b == '0);
    assign w_lastIter = (r_cnt == c_CNT_W'(1));

    // Remainder stays below the divisor, so the WIDTH+1-bit difference MSB is a valid sign.
    assign w_shiftRem = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_shiftRem - {1'b0, r_divisor};
    assign w_qBit     = ~w_diff[WIDTH];
    assign w_remNext  = w_qBit ? w_diff[WIDTH-1:0] : w_shiftRem[WIDTH-1:0];
    assign w_quoNext  = {r_quo[WIDTH-2:0], w_qBit};

    assign w_quoFix   = r_divZero ? '1 : (r_negQuo ? (~w_quoNext + 1'b1) : w_quoNext);
    assign w_remFix   = r_negRem ? (~w_remNext + 1'b1) : w_remNext;

    always_comb begin
        w_nextState = r_state;
        stall_div   = 1'b0;
        ready       = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall_div = w_accept;
                if (w_accept) begin
`ifdef DIV_EARLY_ZERO_EN
                    w_nextState = w_bZero ? S_DONE : S_RUN;
`else
                    w_nextState = S_RUN;
`endif
                end
            end
            S_RUN: begin
                stall_div = ~annul;
                if (annul)
                    w_nextState = S_IDLE;
                else if (w_lastIter)
                    w_nextState = S_DONE;
            end
            S_DONE: begin
                ready       = ~annul;
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_negQuo  <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
            r_prevQuo <= '0;
            r_prevRem <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rem     <= '0;
                        r_quo     <= w_aMag;
                        r_divisor <= w_bMag;
                        r_negQuo  <= w_aNeg ^ w_bNeg;
                        r_negRem  <= w_aNeg;
                        r_divZero <= w_bZero;
                        r_cnt     <= c_CNT_W'(WIDTH);
`ifdef DIV_EARLY_ZERO_EN
                        if (w_bZero) begin
                            r_prevQuo <= quotient;
                            r_prevRem <= remainder;
                            quotient  <= '1;
                            remainder <= a;
                        end
`endif
                    end
                end
                S_RUN: begin
                    if (!annul) begin
                        r_rem <= w_remNext;
                        r_quo <= w_quoNext;
                        r_cnt <= r_cnt - c_CNT_W'(1);
                        if (w_lastIter) begin
                            r_prevQuo <= quotient;
                            r_prevRem <= remainder;
                            quotient  <= w_quoFix;
                            remainder <= w_remFix;
                        end
                    end
                end
                S_DONE: begin
                    // An annulled DONE never writes HI/LO, so roll the outputs back.
                    if (annul) begin
                        quotient  <= r_prevQuo;
                        remainder <= r_prevRem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Self-checking bench for div_unit against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             resetn;
    logic             start;
    logic             signed_div;
    logic             annul;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             stall_div;
    logic             ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    int checks   = 0;
    int failures = 0;
    logic [WIDTH-1:0] lastQ = '0;
    logic [WIDTH-1:0] lastR = '0;

    div_unit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .a          (a),
        .b          (b),
        .stall_div  (stall_div),
        .ready      (ready),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                                  input bit sg, output logic [WIDTH-1:0] q,
                                  output logic [WIDTH-1:0] r);
        if (db == 0) begin
            q = '1;
            r = da;
        end else if (!sg) begin
            q = da / db;
            r = da % db;
        end else if (da == 32'h8000_0000 && db == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = '0;
        end else begin
            q = $signed(da) / $signed(db);
            r = $signed(da) % $signed(db);
        end
    endfunction

    task automatic doDiv(input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db, input bit sg);
        logic [WIDTH-1:0] eq, er;
        int  lat;
        int  expLat;
        bit  seen;
        bit  stallOk;
        model(da, db, sg, eq, er);
        expLat = WIDTH + 1;
`ifdef DIV_EARLY_ZERO_EN
        if (db == 0) expLat = 1;
`endif
        @(negedge clk);
        a = da; b = db; signed_div = sg; start = 1'b1;
        #1 checkVal("stall_accept", {63'd0, stall_div}, 64'd1);
        lat = 0; seen = 0; stallOk = 1;
        while (!seen && lat < 100) begin
            @(posedge clk);
            #1;
            if (lat == 0) begin
                // Operands are only sampled at acceptance; scramble them afterwards.
                start = 1'b0; a = $urandom; b = $urandom; signed_div = 1'($urandom);
            end
            lat++;
            @(negedge clk);
            if (ready) seen = 1;
            else if (!stall_div) stallOk = 0;
        end
        checkVal("latency", 64'(lat), 64'(expLat));
        checkVal("stall_run", {63'd0, stallOk}, 64'd1);
        checkVal("stall_done", {63'd0, stall_div}, 64'd0);
        checkVal("quotient", 64'(quotient), 64'(eq));
        checkVal("remainder", 64'(remainder), 64'(er));
        lastQ = eq; lastR = er;
        @(negedge clk);
        checkVal("ready_pulse", {63'd0, ready}, 64'd0);
        checkVal("hold_q", 64'(quotient), 64'(eq));
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        bit  rs;
        bit  sawReady;
        bit  stallLow;
        resetn = 1'b0; start = 1'b0; signed_div = 1'b0; annul = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checkVal("rst_stall", {63'd0, stall_div}, 64'd0);
        checkVal("rst_ready", {63'd0, ready}, 64'd0);
        checkVal("rst_q", 64'(quotient), 64'd0);
        checkVal("rst_r", 64'(remainder), 64'd0);

        doDiv(32'd100, 32'd7, 1'b0);
        doDiv(32'hFFFF_FFF9, 32'd2, 1'b1);
        doDiv(32'd7, 32'hFFFF_FFFE, 1'b1);
        doDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        doDiv(32'h1234_5678, 32'd0, 1'b0);
        doDiv(32'hFFFF_FFFF, 32'd1, 1'b0);

        // Annul mid-RUN: stall drops at once, no ready, results retained.
        @(negedge clk);
        a = 32'd50; b = 32'd3; signed_div = 1'b0; start = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1 start = 1'b0;
        end
        @(negedge clk);
        annul = 1'b1;
        #1 checkVal("annul_stall", {63'd0, stall_div}, 64'd0);
        @(posedge clk);
        #1 annul = 1'b0;
        sawReady = 0; stallLow = 1;
        repeat (40) begin
            @(negedge clk);
            if (ready) sawReady = 1;
            if (stall_div) stallLow = 0;
        end
        checkVal("annul_no_ready", {63'd0, sawReady}, 64'd0);
        checkVal("annul_idle", {63'd0, stallLow}, 64'd1);
        checkVal("annul_hold_q", 64'(quotient), 64'(lastQ));
        checkVal("annul_hold_r", 64'(remainder), 64'(lastR));
        doDiv(32'd9, 32'd3, 1'b0);

        // Asynchronous reset mid-RUN.
        @(negedge clk);
        a = 32'd1000; b = 32'd9; signed_div = 1'b0; start = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1 start = 1'b0;
        end
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checkVal("midrst_stall", {63'd0, stall_div}, 64'd0);
        checkVal("midrst_ready", {63'd0, ready}, 64'd0);
        checkVal("midrst_q", 64'(quotient), 64'd0);
        checkVal("midrst_r", 64'(remainder), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        doDiv(32'd12345, 32'd67, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = WIDTH'($urandom_range(1, 15));
                2:       rb = -WIDTH'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            rs = 1'($urandom);
            doDiv(ra, rb, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
